w_block_packer: RTL and testbench

//  Producer side of the SHA-256 message-block handshake (en / W_in / en_next) for the miner core.

---
 rtl/w_block_packer.sv | 127 ++++++++++++
 tb/tb_w_block_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/w_block_packer.sv
// SHA-256 message-block packer: gathers WORD_W stream words MSB-first into one block and
// holds it on W_in/en until en_next. Define BYTE_SWAP_EN to byte-reverse each word (WORD_W=32).
module w_block_slot #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              clr,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset || clr) q <= '0;
    else if (we)       q <= d;
  end
endmodule

module w_block_packer #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 16,
  parameter int BLK_W   = WORD_W*N_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              flush,
  output logic [BLK_W-1:0]  W_in,
  output logic              en,
  input  logic              en_next,
  output logic              len_err,
  output logic [15:0]       blk_count
);
  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [1:0] {FILL, PRESENT, RELEASE} state_t;

  state_t                          state, state_nx;
  logic [CNT_W-1:0]                cnt, cnt_nx;
  logic                            wr, clr, err_set, ack, accept, last_slot;
  logic [WORD_W-1:0]               word;
  logic [0:N_WORDS-1][WORD_W-1:0]  slots;

`ifdef BYTE_SWAP_EN
  assign word = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign word = s_data;
`endif

  // s_ready drops combinationally in the reset cycle, whatever state was left behind
  assign s_ready   = reset && (state == FILL);
  assign en        = (state == PRESENT);
  assign accept    = s_valid && s_ready;
  assign last_slot = (cnt == CNT_W'(N_WORDS-1));
  assign W_in      = slots;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr       = 1'b0;
    clr      = 1'b0;
    err_set  = 1'b0;
    ack      = 1'b0;
    case (state)
      FILL: begin
        if (flush) begin
          cnt_nx = '0;
          clr    = 1'b1;
        end else if (accept) begin
          if (s_last && last_slot) begin
            wr       = 1'b1;
            cnt_nx   = '0;
            state_nx = PRESENT;
          end else if (s_last || last_slot) begin
            // framing broken: drop the whole block, the offending word included
            err_set = 1'b1;
            clr     = 1'b1;
            cnt_nx  = '0;
          end else begin
            wr     = 1'b1;
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      PRESENT: begin
        if (en_next) begin
          ack      = 1'b1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        clr      = 1'b1;
        cnt_nx   = '0;
        state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      cnt       <= '0;
      len_err   <= 1'b0;
      blk_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (err_set) len_err   <= 1'b1;
      if (ack)     blk_count <= blk_count + 16'd1;
    end
  end

  for (genvar g = 0; g < N_WORDS; g++) begin : g_slot
    w_block_slot #(.WORD_W(WORD_W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (wr && (cnt == CNT_W'(g))),
      .clr   (clr),
      .d     (word),
      .q     (slots[g])
    );
  end
endmodule

// File: tb/tb_w_block_packer.sv
// Bench for w_block_packer: queue-based block model checked every cycle, directed scenarios
// pinned with literal blocks, then random traffic. Honours BYTE_SWAP_EN like the design.
module tb_w_block_packer;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = 16;
  localparam int BLK_W   = WORD_W*N_WORDS;

  logic              clk = 1'b0;
  logic              reset = 1'b0, s_valid = 1'b0, s_last = 1'b0, flush = 1'b0, en_next = 1'b0;
  logic [WORD_W-1:0] s_data = '0;
  logic              s_ready, en, len_err;
  logic [BLK_W-1:0]  W_in;
  logic [15:0]       blk_count;

  w_block_packer #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .flush(flush), .W_in(W_in), .en(en), .en_next(en_next),
    .len_err(len_err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [31:0] hdr [16] = '{32'h02000000, 32'h671D0E2F, 32'hF45DD1E9, 32'h27A51219,
                            32'hD1CA1065, 32'hC93B0C4E, 32'h8840290A, 32'h00000000,
                            32'h00000000, 32'h2CD900FC, 32'h3513260D, 32'hF5BD2EAB,
                            32'hFD456CD2, 32'hB3D2BACE, 32'h30CC0782, 32'h15A907C0};
  localparam logic [BLK_W-1:0] BLK1 = {
    32'h02000000, 32'h671D0E2F, 32'hF45DD1E9, 32'h27A51219,
    32'hD1CA1065, 32'hC93B0C4E, 32'h8840290A, 32'h00000000,
    32'h00000000, 32'h2CD900FC, 32'h3513260D, 32'hF5BD2EAB,
    32'hFD456CD2, 32'hB3D2BACE, 32'h30CC0782, 32'h15A907C0};

  function automatic logic [31:0] xf(input logic [31:0] d);
`ifdef BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Model: words of the block in progress, whether it is being presented or in its gap cycle
  logic [31:0] mq[$];
  bit          m_pres = 0, m_rel = 0, m_lerr = 0, started = 0;
  logic [15:0] m_bcnt = '0;

  function automatic logic [BLK_W-1:0] m_blk();
    logic [BLK_W-1:0] r = '0;
    foreach (mq[k]) r[BLK_W-1-k*WORD_W -: WORD_W] = mq[k];
    return r;
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      mq.delete(); m_pres = 0; m_rel = 0; m_lerr = 0; m_bcnt = '0;
    end else if (m_rel) begin
      m_rel = 0; mq.delete();
    end else if (m_pres) begin
      if (en_next) begin m_pres = 0; m_rel = 1; m_bcnt = m_bcnt + 16'd1; end
    end else if (flush) begin
      mq.delete();
    end else if (s_valid) begin
      mq.push_back(xf(s_data));
      if (mq.size() == N_WORDS) begin
        if (s_last) m_pres = 1;
        else begin m_lerr = 1; mq.delete(); end
      end else if (s_last) begin
        m_lerr = 1; mq.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("en", BLK_W'(en), BLK_W'(m_pres));
      chk("s_ready", BLK_W'(s_ready), BLK_W'(reset && !m_pres && !m_rel));
      chk("W_in", W_in, m_blk());
      chk("len_err", BLK_W'(len_err), BLK_W'(m_lerr));
      chk("blk_count", BLK_W'(blk_count), BLK_W'(m_bcnt));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [31:0] d, input bit last);
    s_valid = 1'b1; s_data = d; s_last = last;
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic feed_blk();
    for (int i = 0; i < N_WORDS; i++) feed(hdr[i], i == N_WORDS-1);
  endtask

  task automatic ack();
    en_next = 1'b1; step(); en_next = 1'b0; step();
  endtask

  initial begin
    step(); step();
    chk("rst_en", BLK_W'(en), '0);
    chk("rst_W_in", W_in, '0);
    chk("rst_blk_count", BLK_W'(blk_count), '0);
    chk("rst_s_ready", BLK_W'(s_ready), '0);
    reset = 1'b1;

    // reference header block
    feed_blk();
    chk("t1_en", BLK_W'(en), BLK_W'(1));
    chk("t1_s_ready", BLK_W'(s_ready), '0);
`ifndef BYTE_SWAP_EN
    chk("t1_W_in", W_in, BLK1);
`endif

    // consumer stalls, then acks
    repeat (20) step();
    chk("t2_en_held", BLK_W'(en), BLK_W'(1));
`ifndef BYTE_SWAP_EN
    chk("t2_W_in_held", W_in, BLK1);
`endif
    en_next = 1'b1; step(); en_next = 1'b0;
    chk("t2_en_drop", BLK_W'(en), '0);
    chk("t2_s_ready_gap", BLK_W'(s_ready), '0);
    step();
    chk("t2_s_ready_back", BLK_W'(s_ready), BLK_W'(1));
    chk("t2_blk_count", BLK_W'(blk_count), BLK_W'(1));

    // early s_last on word 5, then a good block
    for (int i = 0; i < 6; i++) feed(hdr[i], i == 5);
    chk("t3_len_err", BLK_W'(len_err), BLK_W'(1));
    feed_blk();
`ifndef BYTE_SWAP_EN
    chk("t3_W_in", W_in, BLK1);
`endif
    ack();
    chk("t3_blk_count", BLK_W'(blk_count), BLK_W'(2));

    // flush after 7 words with a word offered in the same cycle
    for (int i = 0; i < 7; i++) feed(hdr[i], 1'b0);
    s_valid = 1'b1; flush = 1'b1; s_data = 32'hDEADBEEF;
    step();
    s_valid = 1'b0; flush = 1'b0;
    feed_blk();
`ifndef BYTE_SWAP_EN
    chk("t4_W_in", W_in, BLK1);
    chk("t4_word0", BLK_W'(W_in[511:480]), BLK_W'(32'h02000000));
`endif
    ack();

    // reset while presenting; a later ack is ignored
    feed_blk();
    reset = 1'b0; step(); reset = 1'b1;
    chk("t5_en", BLK_W'(en), '0);
    chk("t5_W_in", W_in, '0);
    chk("t5_blk_count", BLK_W'(blk_count), '0);
    chk("t5_len_err", BLK_W'(len_err), '0);
    en_next = 1'b1; step(); en_next = 1'b0;
    chk("t5_ack_ignored", BLK_W'(blk_count), '0);

`ifdef BYTE_SWAP_EN
    feed(32'h00000002, 1'b0);
    chk("t6_swap", BLK_W'(W_in[511:480]), BLK_W'(32'h02000000));
    flush = 1'b1; step(); flush = 1'b0;
`endif

    // random traffic
    repeat (4000) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = $urandom;
      s_last  = (mq.size() == N_WORDS-1) ^ (($urandom % 24) == 0);
      flush   = ($urandom % 50) == 0;
      en_next = ($urandom % 3) == 0;
      reset   = ($urandom % 600) != 0;
      step();
    end
    s_valid = 1'b0; s_last = 1'b0; flush = 1'b0; en_next = 1'b0; reset = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
